// File: rtl/sa_col_deskew_buf.sv
// sa_col_deskew_buf
//   Re-aligns skewed systolic-array column results. Each column is captured
//   into its own small FIFO; once every column holds at least one entry the
//   heads form one aligned row, released over a valid/ready handshake.
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (clears storage too)
//   i_wren       per-column write enable, bit c = column c
//   i_data       column results, column c at [c*DW +: DW]
//   i_flush      synchronous clear of pointers, counts, overflow, row count
//   i_ready      downstream ready
//   o_valid      aligned row available (all columns non-empty)
//   o_data       aligned row, column c at [c*DW +: DW]
//   o_col_empty  per-column FIFO empty
//   o_overflow   sticky: a write was dropped on a full column
//   o_row_cnt    rows popped since reset/flush, wraps
module sa_col_deskew_buf #(
  parameter int COL   = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [COL-1:0]       i_wren,
  input  logic [COL*DW-1:0]    i_data,
  input  logic                 i_flush,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [COL*DW-1:0]    o_data,
  output logic [COL-1:0]       o_col_empty,
  output logic                 o_overflow,
  output logic [CNT_W-1:0]     o_row_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr [COL];
  logic [AW-1:0] rd_ptr [COL];
  logic [AW:0]   cnt    [COL];
  logic [DW-1:0] mem    [COL][DEPTH];

  logic [COL-1:0] not_empty;
  logic [COL-1:0] full;
  logic [COL-1:0] wr_acc;
  logic           pop;

  assign o_valid     = &not_empty;
  assign pop         = o_valid & i_ready;
  assign o_col_empty = ~not_empty;

  always_comb begin
    not_empty = '0;
    full      = '0;
    wr_acc    = '0;
    o_data    = '0;
    for (int unsigned c = 0; c < COL; c++) begin
      not_empty[c]        = (cnt[c] != '0);
      full[c]             = (cnt[c] == CW'(DEPTH));
      // A pop frees the slot the write lands in, so a full column may still
      // accept a write in the same cycle.
      wr_acc[c]           = i_wren[c] & (~full[c] | pop);
      o_data[c*DW +: DW]  = mem[c][rd_ptr[c]];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < COL; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          mem[c][d] <= '0;
        end
      end
      o_overflow <= 1'b0;
      o_row_cnt  <= '0;
    end else if (i_flush) begin
      for (int unsigned c = 0; c < COL; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      o_overflow <= 1'b0;
      o_row_cnt  <= '0;
    end else begin
      for (int unsigned c = 0; c < COL; c++) begin
        if (wr_acc[c]) begin
          mem[c][wr_ptr[c]] <= i_data[c*DW +: DW];
          wr_ptr[c]         <= wr_ptr[c] + 1'b1;
        end
        if (pop) begin
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        end
        if (wr_acc[c] && !pop) begin
          cnt[c] <= cnt[c] + 1'b1;
        end else if (!wr_acc[c] && pop) begin
          cnt[c] <= cnt[c] - 1'b1;
        end
      end
      if (|(i_wren & full & ~{COL{pop}})) begin
        o_overflow <= 1'b1;
      end
      if (pop) begin
        o_row_cnt <= o_row_cnt + 1'b1;
      end
    end
  end

endmodule
